servo_pwm_multi: RTL and testbench
==================================

SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter NUM_CH, default 2: servo channels, legal 1..8.
REQ-002 Parameter TICK_DIV, default 50: clk cycles per 1 us tick, legal 2..1023.
REQ-003 Parameter PERIOD_US, default 20000: frame length in ticks, legal 100..65535.
REQ-004 Parameters MIN_US 1000 / MAX_US 2000: pulse-width clamp limits in ticks, MIN_US < MAX_US < PERIOD_US.
REQ-005 clk  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-006 reset_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 address  in  4  Avalon-MM word address.
REQ-008 write / read  in  1 each  Avalon-MM strobes, single-cycle, no waitrequest.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data, fixed read latency 1.
REQ-011 servo_out  out  NUM_CH  PWM outputs, bit i = channel i.
REQ-012 pos_out  out  16*NUM_CH  current applied width per channel in ticks, channel i at [16i+15:16i].
REQ-013 frame_start  out  1  one-cycle pulse at each frame boundary.

Function
REQ-014 Register map: 0x0-0x7 TARGET[ch] (bits 15:0); 0x8 CTRL (bits NUM_CH-1:0 enable); 0x9 SLEW (bits 15:0, ticks per frame, 0 = unlimited); 0xA FRAME (bits 15:0 frame counter, read-only).
REQ-015 TARGET write to ch >= NUM_CH, writes to 0xA and 0xB-0xF SHALL be ignored; reads of those addresses return 0.
REQ-016 TARGET write value SHALL be clamped: < MIN_US stores MIN_US, > MAX_US stores MAX_US, else stored as-is; readback returns the stored value.
REQ-017 Unused readdata bits SHALL read 0; readdata updates one cycle after read=1 and holds otherwise.
REQ-018 Prescaler counts 0..TICK_DIV-1, wraps; tick asserted in the cycle it equals TICK_DIV-1.
REQ-019 Frame counter advances by 1 on tick, wraps from PERIOD_US-1 to 0; boundary = tick while frame counter = PERIOD_US-1.
REQ-020 frame_start SHALL be 1 exactly in the cycle after the boundary cycle (frame counter newly 0).
REQ-021 At boundary, per channel: d = TARGET - CUR; if SLEW = 0 or |d| <= SLEW then CUR := TARGET, else CUR := CUR +/- SLEW toward TARGET; unsigned 16-bit arithmetic, no overflow (operands <= MAX_US).
REQ-022 At boundary, per-channel enable shadow := CTRL bit; shadow changes only at boundaries (glitch-free enable/disable).
REQ-023 servo_out[i] registered: 1 while shadow[i] = 1 and frame counter < CUR[i], else 0; pulse width = CUR[i] ticks exactly, rising edge in frame_start cycle.
REQ-024 Register write in the boundary cycle: boundary update uses pre-write TARGET/CTRL/SLEW; new value takes effect at the next boundary.
REQ-025 pos_out SHALL reflect CUR registers directly; CUR never leaves [MIN_US, MAX_US].
REQ-026 read and write asserted together: write performed, readdata returns pre-write value.

Reset
REQ-027 With reset_n = 0 at a rising clk: TARGET[i] = CUR[i] = (MIN_US+MAX_US)/2 (1500 default), CTRL = 0, shadow = 0, SLEW = 0, prescaler = 0, frame counter = 0, servo_out = 0, frame_start = 0, readdata = 0.
REQ-028 Reset mid-pulse SHALL drive servo_out low in the next cycle; no partial pulse after reset release until enabled and a boundary occurs.
REQ-029 First boundary after reset release occurs TICK_DIV*PERIOD_US cycles after release.

Verification (TICK_DIV=2, PERIOD_US=100, MIN_US=10, MAX_US=50, NUM_CH=2)
REQ-030 Reset, write TARGET0=20, CTRL=0x1 -> after next frame_start servo_out[0] high 40 cycles per 200-cycle frame; servo_out[1] stays 0; pos_out[15:0]=20.
REQ-031 Write TARGET1=5 then 99, read back -> readdata 10 then 50.
REQ-032 SLEW=4, CUR0=30, write TARGET0=41 -> pos_out[15:0] 34, 38, 41 on successive boundaries.
REQ-033 Write CTRL=0 mid-pulse -> current pulse completes full width; no pulse from next frame.
REQ-034 Write TARGET0 exactly in boundary cycle -> old target applied this frame, new target next frame.
REQ-035 Assert reset_n=0 mid-pulse -> servo_out=0 next cycle, all registers at REQ-027 values, reads of 0x2-0x7 and 0xB return 0.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// Multi-channel RC servo PWM generator with an Avalon-MM register file.
// Per-channel pulse width is slew-limited and latched only at frame boundaries.
module servo_pwm_multi #(
    parameter int NUM_CH    = 2,
    parameter int TICK_DIV  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           address,
    input  logic                 write,
    input  logic                 read,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [NUM_CH-1:0]    servo_out,
    output logic [16*NUM_CH-1:0] pos_out,
    output logic                 frame_start
);

    localparam logic [9:0]  TICK_LAST  = 10'(TICK_DIV - 1);
    localparam logic [15:0] FRAME_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0] W_MIN      = 16'(MIN_US);
    localparam logic [15:0] W_MAX      = 16'(MAX_US);
    localparam logic [15:0] W_MID      = 16'((MIN_US + MAX_US) / 2);

    logic [9:0]        presc_q, presc_d;
    logic [15:0]       frm_q, frm_d;
    logic [15:0]       tgt_q [NUM_CH];
    logic [15:0]       tgt_d [NUM_CH];
    logic [15:0]       cur_q [NUM_CH];
    logic [15:0]       cur_d [NUM_CH];
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] servo_q, servo_d;
    logic [15:0]       slew_q, slew_d;
    logic              fs_q, fs_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              tick, boundary;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign tick     = (presc_q == TICK_LAST);
    assign boundary = tick && (frm_q == FRAME_LAST);

    function automatic logic [15:0] clamp_w(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v < W_MIN) r = W_MIN;
        if (v > W_MAX) r = W_MAX;
        return r;
    endfunction

    // Move cur toward tgt by at most slew; slew of zero means jump straight there.
    function automatic logic [15:0] slew_step(input logic [15:0] cur,
                                              input logic [15:0] tgt,
                                              input logic [15:0] slew);
        logic [15:0] diff;
        logic [15:0] r;
        if (tgt >= cur) begin
            diff = tgt - cur;
            r    = (slew == 16'd0 || diff <= slew) ? tgt : cur + slew;
        end else begin
            diff = cur - tgt;
            r    = (slew == 16'd0 || diff <= slew) ? tgt : cur - slew;
        end
        return r;
    endfunction

    always_comb begin
        presc_d  = tick ? 10'd0 : presc_q + 10'd1;
        frm_d    = frm_q;
        tgt_d    = tgt_q;
        cur_d    = cur_q;
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        slew_d   = slew_q;
        fs_d     = boundary;
        servo_d  = '0;
        rdata_d  = rdata_q;

        if (tick) begin
            frm_d = boundary ? 16'd0 : frm_q + 16'd1;
        end

        // Boundary update reads only _q values, so a same-cycle write lands next frame.
        if (boundary) begin
            shadow_d = ctrl_q;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_d[i] = slew_step(cur_q[i], tgt_q[i], slew_q);
            end
        end

        if (write) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i)) tgt_d[i] = clamp_w(writedata[15:0]);
            end
            if (address == 4'h8) ctrl_d = writedata[NUM_CH-1:0];
            if (address == 4'h9) slew_d = writedata[15:0];
        end

        if (read) begin
            rdata_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (address == 4'(i)) rdata_d = {16'd0, tgt_q[i]};
            end
            case (address)
                4'h8:    rdata_d = {{(32-NUM_CH){1'b0}}, ctrl_q};
                4'h9:    rdata_d = {16'd0, slew_q};
                4'hA:    rdata_d = {16'd0, frm_q};
                default: ;
            endcase
        end

        // Outputs registered from next-state so the edge aligns with frame_start.
        for (int i = 0; i < NUM_CH; i++) begin
            servo_d[i] = shadow_d[i] && (frm_d < cur_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q  <= '0;
            frm_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= W_MID;
                cur_q[i] <= W_MID;
            end
            ctrl_q   <= '0;
            shadow_q <= '0;
            slew_q   <= '0;
            servo_q  <= '0;
            fs_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            frm_q    <= frm_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            ctrl_q   <= ctrl_d;
            shadow_q <= shadow_d;
            slew_q   <= slew_d;
            servo_q  <= servo_d;
            fs_q     <= fs_d;
            rdata_q  <= rdata_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
        assign pos_out[16*g +: 16] = cur_q[g];
    end

    assign servo_out   = servo_q;
    assign frame_start = fs_q;
    assign readdata    = rdata_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Randomized and directed bench for servo_pwm_multi against a frame-level reference model.
module tb_servo_pwm_multi;

    localparam int TD   = 2;
    localparam int P    = 100;
    localparam int MINW = 10;
    localparam int MAXW = 50;
    localparam int NCH  = 2;
    localparam int FC   = TD * P;
    localparam int MID  = (MINW + MAXW) / 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        address = '0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [NCH-1:0]    servo_out;
    logic [16*NCH-1:0] pos_out;
    logic              frame_start;

    servo_pwm_multi #(
        .NUM_CH(NCH), .TICK_DIV(TD), .PERIOD_US(P), .MIN_US(MINW), .MAX_US(MAXW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .servo_out(servo_out),
        .pos_out(pos_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: time since release decides frame position and boundaries.
    int unsigned n;
    int          m_tgt [NCH];
    int          m_cur [NCH];
    int          m_ctrl, m_slew, m_rd, m_pos_pre;
    bit          m_shadow [NCH];
    bit          m_fs, m_bnd, m_valid = 0;

    function automatic int clampv(int v);
        if (v < MINW) return MINW;
        if (v > MAXW) return MAXW;
        return v;
    endfunction

    function automatic int step(int c, int t, int s);
        int d;
        d = (t > c) ? t - c : c - t;
        if (s == 0 || d <= s) return t;
        return (t > c) ? c + s : c - s;
    endfunction

    function automatic int reg_val(int a, int frame_pos);
        if (a < NCH) return m_tgt[a];
        if (a == 8)  return m_ctrl;
        if (a == 9)  return m_slew;
        if (a == 10) return frame_pos;
        return 0;
    endfunction

    always @(posedge clk) begin
        m_valid = 1;
        if (!reset_n) begin
            n = 0; m_ctrl = 0; m_slew = 0; m_rd = 0; m_fs = 0;
            for (int i = 0; i < NCH; i++) begin
                m_tgt[i] = MID; m_cur[i] = MID; m_shadow[i] = 0;
            end
        end else begin
            m_pos_pre = (n / TD) % P;
            m_bnd     = (n % FC) == FC - 1;
            if (read) m_rd = reg_val(int'(address), m_pos_pre);
            if (m_bnd) begin
                for (int i = 0; i < NCH; i++) begin
                    m_shadow[i] = m_ctrl[i];
                    m_cur[i]    = step(m_cur[i], m_tgt[i], m_slew);
                end
            end
            if (write) begin
                if (int'(address) < NCH) m_tgt[address] = clampv(int'(writedata[15:0]));
                if (address == 4'h8) m_ctrl = int'(writedata) & ((1 << NCH) - 1);
                if (address == 4'h9) m_slew = int'(writedata[15:0]);
            end
            m_fs = m_bnd;
            n++;
        end
    end

    function automatic logic [NCH-1:0] exp_servo();
        logic [NCH-1:0] r;
        int pos;
        pos = (n / TD) % P;
        for (int i = 0; i < NCH; i++) r[i] = m_shadow[i] && (pos < m_cur[i]);
        return r;
    endfunction

    function automatic logic [16*NCH-1:0] exp_pos();
        logic [16*NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[16*i +: 16] = 16'(m_cur[i]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            chk("servo", servo_out, exp_servo());
            chk("fstart", frame_start, m_fs);
            chk("pos", pos_out, exp_pos());
            chk("rdata", readdata, 32'(m_rd));
        end
    end

    int rc;
    always @(posedge clk) begin
        if (!reset_n) rc = 0;
        else rc++;
    end

    task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d);
        write = w; read = r; address = a; writedata = d;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
    endtask

    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 500);
        chk("fs_seen", frame_start, 1'b1);
    endtask

    int hi0, hi1, k;
    logic [3:0]  ra;
    logic [31:0] rd_w;
    int op;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_servo", servo_out, '0);
        chk("rst_pos", pos_out, {16'(MID), 16'(MID)});
        reset_n = 1'b1;

        // Enable channel 0 at width 20: 40 high cycles per 200-cycle frame.
        bus(1, 0, 4'h0, 32'd20);
        bus(1, 0, 4'h8, 32'h1);
        wait_fs();
        chk("first_fs_latency", rc, FC);
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < FC; i++) begin
            hi0 += int'(servo_out[0]); hi1 += int'(servo_out[1]);
            @(negedge clk);
        end
        chk("width_ch0", hi0, 40);
        chk("width_ch1", hi1, 0);
        chk("pos0_20", pos_out[15:0], 16'd20);

        // Clamp readback.
        bus(1, 0, 4'h1, 32'd5);
        bus(0, 1, 4'h1, 32'd0);
        chk("clamp_lo", readdata, 32'd10);
        bus(1, 0, 4'h1, 32'd99);
        bus(0, 1, 4'h1, 32'd0);
        chk("clamp_hi", readdata, 32'd50);

        // Slew-limited approach 30 -> 41 by 4 per frame.
        bus(1, 0, 4'h9, 32'd0);
        bus(1, 0, 4'h0, 32'd30);
        wait_fs();
        chk("slew_start", pos_out[15:0], 16'd30);
        bus(1, 0, 4'h9, 32'd4);
        bus(1, 0, 4'h0, 32'd41);
        wait_fs(); chk("slew_34", pos_out[15:0], 16'd34);
        wait_fs(); chk("slew_38", pos_out[15:0], 16'd38);
        wait_fs(); chk("slew_41", pos_out[15:0], 16'd41);

        // Write in the boundary cycle: old target this frame, new one the next.
        bus(1, 0, 4'h9, 32'd0);
        bus(1, 0, 4'h0, 32'd20);
        wait_fs();
        chk("bnd_pre", pos_out[15:0], 16'd20);
        k = 0;
        while ((rc % FC) != FC - 1 && k < 400) begin
            @(negedge clk); k++;
        end
        bus(1, 0, 4'h0, 32'd45);
        chk("bnd_fs", frame_start, 1'b1);
        chk("bnd_old", pos_out[15:0], 16'd20);
        wait_fs();
        chk("bnd_new", pos_out[15:0], 16'd45);

        // Disable mid-pulse: this pulse completes (90 cycles), next frame is silent.
        wait_fs();
        hi0 = 0;
        for (int i = 0; i < FC; i++) begin
            hi0 += int'(servo_out[0]);
            if (i == 10) begin address = 4'h8; writedata = 32'd0; write = 1'b1; end
            else write = 1'b0;
            @(negedge clk);
        end
        write = 1'b0;
        chk("dis_full_pulse", hi0, 90);
        hi0 = 0;
        for (int i = 0; i < FC; i++) begin
            hi0 += int'(servo_out[0]);
            @(negedge clk);
        end
        chk("dis_no_pulse", hi0, 0);

        // Reset mid-pulse.
        bus(1, 0, 4'h9, 32'd7);
        bus(1, 0, 4'h8, 32'h3);
        wait_fs();
        repeat (4) @(negedge clk);
        chk("pre_rst_high", servo_out[0], 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_servo", servo_out, '0);
        chk("rst_mid_pos", pos_out, {16'(MID), 16'(MID)});
        chk("rst_mid_rdata", readdata, 32'd0);
        reset_n = 1'b1;
        for (int a = 2; a <= 11; a++) begin
            if (a <= 7 || a == 11) begin
                bus(0, 1, 4'(a), 32'd0);
                chk("rd_unmapped", readdata, 32'd0);
            end
        end
        bus(0, 1, 4'h0, 32'd0); chk("rst_tgt0", readdata, 32'(MID));
        bus(0, 1, 4'h8, 32'd0); chk("rst_ctrl", readdata, 32'd0);
        bus(0, 1, 4'h9, 32'd0); chk("rst_slew", readdata, 32'd0);

        // Random traffic against the model.
        for (int it = 0; it < 4000; it++) begin
            op = int'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            if (ra == 4'h9)                 rd_w = $urandom_range(0, 12);
            else if ($urandom_range(0, 7) == 0) rd_w = $urandom;
            else                            rd_w = $urandom_range(0, 70);
            case (op)
                0, 1:    bus(1, 0, ra, rd_w);
                2:       bus(0, 1, ra, rd_w);
                3:       bus(1, 1, ra, rd_w);
                default: @(negedge clk);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
